data_io_pump: RTL and testbench

- SPI master that drives the download side of the data_io SPI slave protocol from inside the FPGA, e.g. a boot-ROM or flash loader standing in for the I/O controller.
- Handshakes for ACK, selects the file index, then streams a byte source as a 0x61 data pump and closes it with 0x62.
- Sits between a byte source (flash/ROM reader) and the SPI_SCK/SPI_SS2/SPI_DI/SPI_DO pins of a data_io instance.

---
 rtl/data_io_pump.sv | 258 +++++++++++++++++++++++++
 tb/tb_data_io_pump.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_io_pump.sv
// data_io_pump: SPI master that plays the I/O-controller role towards a data_io
// slave. It checks the ACK byte, selects a file index, streams a byte source with
// the 0x61 pump command and closes the download with 0x62.
//
// Source handshake: the payload byte is captured on the clock edge that raises
// src_ready. src_ready is therefore high during the cycle after the capture, and
// the source advances to its next byte when it sees src_ready high. Bytes are
// needed at most once per 8*2*CLK_DIV cycles, so this lag never loses a byte.
module data_io_pump #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned SS_GAP  = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  index,
    input  logic [24:0] length,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        SPI_SCK,
    output logic        SPI_SS2,
    output logic        SPI_DI,
    input  logic        SPI_DO
);

    localparam int unsigned LEN_W   = 25;
    localparam int unsigned CNT_MAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [7:0] ACK_OK   = 8'h4B;
    localparam logic [7:0] CMD_IDX  = 8'h55;
    localparam logic [7:0] CMD_PUMP = 8'h61;
    localparam logic [7:0] CMD_END  = 8'h62;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SS_GAP - 1);

    // Bit-level engine states; LOAD fetches the next byte (and waits for the source).
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOW,
        ST_HIGH,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Which SS2-framed transaction of the download is in progress.
    typedef enum logic [1:0] {
        PH_ACK,
        PH_IDX,
        PH_PUMP,
        PH_END
    } phase_t;

    state_t             state;
    phase_t             phase;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_cnt;
    logic [1:0]         tx_cnt;
    logic [7:0]         tx_sr;
    logic [7:0]         rx_sr;
    logic [7:0]         index_q;
    logic [LEN_W-1:0]   remaining;
    logic               pad_pending;

    logic               nxt_have;
    logic               nxt_src;
    logic               nxt_pad;
    logic [7:0]         nxt_byte;
    logic [7:0]         load_byte;

    // Next byte of the current transaction, given how many bytes were already loaded.
    always_comb begin
        nxt_have = 1'b0;
        nxt_src  = 1'b0;
        nxt_pad  = 1'b0;
        nxt_byte = 8'h00;
        case (phase)
            PH_ACK: begin
                nxt_have = (tx_cnt != 2'd2);
            end
            PH_IDX: begin
                if (tx_cnt == 2'd0) begin
                    nxt_have = 1'b1;
                    nxt_byte = CMD_IDX;
                end else if (tx_cnt == 2'd1) begin
                    nxt_have = 1'b1;
                    nxt_byte = index_q;
                end
            end
            PH_PUMP: begin
                if (tx_cnt == 2'd0) begin
                    nxt_have = 1'b1;
                    nxt_byte = CMD_PUMP;
                end else if (remaining != '0) begin
                    nxt_have = 1'b1;
                    nxt_src  = 1'b1;
                end else if (pad_pending) begin
                    nxt_have = 1'b1;
                    nxt_pad  = 1'b1;
                end
            end
            PH_END: begin
                if (tx_cnt == 2'd0) begin
                    nxt_have = 1'b1;
                    nxt_byte = CMD_END;
                end
            end
            default: begin
                nxt_have = 1'b0;
            end
        endcase
        load_byte = nxt_src ? src_data : nxt_byte;
    end

    // Download sequencer, SPI byte engine and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            phase       <= PH_ACK;
            cnt         <= '0;
            bit_cnt     <= '0;
            tx_cnt      <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            index_q     <= '0;
            remaining   <= '0;
            pad_pending <= 1'b0;
            src_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            SPI_SCK     <= 1'b0;
            SPI_SS2     <= 1'b1;
            SPI_DI      <= 1'b0;
        end else begin
            src_ready <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start landing on the done cycle belongs to the finished download.
                    if (start && !done) begin
                        index_q     <= index;
                        remaining   <= length;
                        pad_pending <= length[0];
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        phase       <= PH_ACK;
                        tx_cnt      <= 2'd0;
                        cnt         <= '0;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // SCK stays low here while a payload byte is not yet available.
                    if (!nxt_src || src_valid) begin
                        SPI_SS2 <= 1'b0;
                        tx_sr   <= load_byte;
                        SPI_DI  <= load_byte[7];
                        bit_cnt <= 3'd0;
                        // First byte: SS2 falls now, so the full low phase follows.
                        // Later bytes: SCK already fell one cycle ago.
                        cnt     <= (tx_cnt == 2'd0) ? CNT_W'(0) : CNT_W'(1);
                        if (tx_cnt != 2'd2) begin
                            tx_cnt <= tx_cnt + 2'd1;
                        end
                        if (nxt_src) begin
                            src_ready <= 1'b1;
                            remaining <= remaining - LEN_W'(1);
                        end
                        if (nxt_pad) begin
                            pad_pending <= 1'b0;
                        end
                        state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (cnt == DIV_LAST) begin
                        SPI_SCK <= 1'b1;
                        rx_sr   <= {rx_sr[6:0], SPI_DO};
                        cnt     <= '0;
                        state   <= ST_HIGH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt == DIV_LAST) begin
                        SPI_SCK <= 1'b0;
                        cnt     <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= nxt_have ? ST_LOAD : ST_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_sr   <= {tx_sr[6:0], 1'b0};
                            SPI_DI  <= tx_sr[6];
                            state   <= ST_LOW;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == DIV_LAST) begin
                        SPI_SS2 <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    // Decisions are taken only after the inter-transaction gap has elapsed.
                    if (cnt == GAP_LAST) begin
                        cnt    <= '0;
                        tx_cnt <= 2'd0;
                        case (phase)
                            PH_ACK: begin
                                if (rx_sr == ACK_OK) begin
                                    phase <= PH_IDX;
                                    state <= ST_LOAD;
                                end else begin
                                    error <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= ST_IDLE;
                                end
                            end
                            PH_IDX: begin
                                phase <= PH_PUMP;
                                state <= ST_LOAD;
                            end
                            PH_PUMP: begin
                                phase <= PH_END;
                                state <= ST_LOAD;
                            end
                            default: begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_io_pump.sv
// Bench for data_io_pump: an SPI slave monitor records every SS2-framed
// transaction as bytes and answers the ACK byte; a transaction-level model
// predicts the byte stream of a whole download from index, payload and ACK.
module tb_data_io_pump;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned SS_GAP  = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [7:0]  index   = 8'h00;
    logic [24:0] length  = 25'd0;
    logic [7:0]  src_data  = 8'h00;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic        SPI_SCK;
    logic        SPI_SS2;
    logic        SPI_DI;
    logic        spi_do_drv = 1'b0;

    data_io_pump #(.CLK_DIV(CLK_DIV), .SS_GAP(SS_GAP)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .start     (start),
        .index     (index),
        .length    (length),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .SPI_SCK   (SPI_SCK),
        .SPI_SS2   (SPI_SS2),
        .SPI_DI    (SPI_DI),
        .SPI_DO    (spi_do_drv)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- byte source ----------------
    logic [7:0] src_buf[$];
    int src_idx   = 0;
    int stall_cnt = 0;
    int stall_pct = 0;
    int stall_max = 1;
    int stall_at  = -1;
    int stall_len = 0;

    initial begin
        forever begin
            @(negedge clk_sys);
            if (src_ready) begin
                src_idx++;
                if (src_idx == stall_at)
                    stall_cnt = stall_len;
                else if (stall_pct > 0 && $urandom_range(99, 0) < stall_pct)
                    stall_cnt = $urandom_range(stall_max, 1);
            end
            if (stall_cnt > 0) begin
                stall_cnt--;
                src_valid = 1'b0;
            end else if (src_idx < src_buf.size()) begin
                src_valid = 1'b1;
                src_data  = src_buf[src_idx];
            end else begin
                src_valid = 1'b0;
                src_data  = 8'h00;
            end
        end
    end

    // ---------------- SPI slave monitor ----------------
    logic [8:0] mon_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] ack_byte = 8'h4B;
    logic [7:0] cur_byte = 8'h00;
    logic       prev_sck = 1'b0;
    logic       prev_ss2 = 1'b1;
    int bit_n    = 0;
    int lo_cnt   = 0;
    int hi_cnt   = 0;
    int gap_cnt  = SS_GAP;
    int done_cnt = 0;
    int rdy_cnt  = 0;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_sck   = 1'b0;
            prev_ss2   = 1'b1;
            bit_n      = 0;
            lo_cnt     = 0;
            hi_cnt     = 0;
            gap_cnt    = SS_GAP;
            spi_do_drv = 1'b0;
        end else begin
            if (!SPI_SS2 && prev_ss2) begin
                check("ss_gap", 32'(gap_cnt >= SS_GAP), 1);
                bit_n  = 0;
                lo_cnt = 0;
            end
            if (SPI_SS2 && !prev_ss2) begin
                check("ss_hold", lo_cnt, CLK_DIV);
                check("txn_bits", bit_n % 8, 0);
            end
            if (SPI_SCK && !prev_sck) begin
                check("sck_while_ss_high", SPI_SS2, 0);
                if (bit_n % 8 != 0 || bit_n == 0)
                    check("sck_low", lo_cnt, CLK_DIV);
                else
                    check("sck_low_min", 32'(lo_cnt >= CLK_DIV), 1);
                cur_byte = {cur_byte[6:0], SPI_DI};
                bit_n++;
                if (bit_n % 8 == 0)
                    mon_q.push_back({(bit_n == 8), cur_byte});
                hi_cnt = 1;
            end else if (SPI_SCK) begin
                hi_cnt++;
            end
            if (!SPI_SCK && prev_sck) begin
                check("sck_high", hi_cnt, CLK_DIV);
                lo_cnt = 1;
            end else if (!SPI_SCK) begin
                lo_cnt++;
            end
            gap_cnt = SPI_SS2 ? gap_cnt + 1 : 0;
            if (done)      done_cnt++;
            if (src_ready) rdy_cnt++;
            // Slave answers with ack_byte during the second byte of a transaction.
            spi_do_drv = (!SPI_SS2 && bit_n / 8 == 1) ? ack_byte[3'(7 - bit_n % 8)] : 1'b0;
            prev_sck = SPI_SCK;
            prev_ss2 = SPI_SS2;
        end
    end

    // ---------------- reference model ----------------
    // Bit 8 marks the first byte of a transaction.
    task automatic model(input logic [7:0] idx, input logic [7:0] ack);
        exp_q.delete();
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b0, 8'h00});
        if (ack == 8'h4B) begin
            exp_q.push_back({1'b1, 8'h55});
            exp_q.push_back({1'b0, idx});
            exp_q.push_back({1'b1, 8'h61});
            foreach (src_buf[i]) exp_q.push_back({1'b0, src_buf[i]});
            if (src_buf.size() % 2 == 1) exp_q.push_back({1'b0, 8'h00});
            exp_q.push_back({1'b1, 8'h62});
        end
    endtask

    task automatic start_download(input logic [7:0] idx, input logic [7:0] ack, input bit poke);
        ack_byte  = ack;
        mon_q.delete();
        done_cnt  = 0;
        rdy_cnt   = 0;
        src_idx   = 0;
        stall_cnt = 0;
        model(idx, ack);
        @(negedge clk_sys);
        index  = idx;
        length = 25'(src_buf.size());
        start  = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_error_clr", error, 0);
        if (poke) begin
            repeat (40) @(negedge clk_sys);
            index  = ~idx;
            length = 25'd7;
            start  = 1'b1;
            @(negedge clk_sys);
            start  = 1'b0;
            index  = idx;
            length = 25'(src_buf.size());
        end
    endtask

    task automatic finish_download(input string name, input logic [7:0] ack);
        bit ok;
        int cyc;
        ok  = (ack == 8'h4B);
        cyc = 0;
        while (busy === 1'b1 && cyc < 20000) begin
            @(negedge clk_sys);
            cyc++;
        end
        check({name, "_timeout"}, busy, 0);
        check({name, "_done_at_end"}, done, 32'(ok));
        check({name, "_error"}, error, 32'(!ok));
        if (ok) start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        check({name, "_start_on_done"}, busy, 0);
        repeat (3) @(negedge clk_sys);
        check({name, "_nbytes"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < mon_q.size()) check({name, "_byte"}, mon_q[i], exp_q[i]);
        check({name, "_done_cnt"}, done_cnt, ok ? 1 : 0);
        check({name, "_rdy_cnt"}, rdy_cnt, ok ? src_buf.size() : 0);
        check({name, "_ss2_idle"}, SPI_SS2, 1);
        check({name, "_sck_idle"}, SPI_SCK, 0);
    endtask

    task automatic fill_random(input int n);
        src_buf.delete();
        for (int i = 0; i < n; i++) src_buf.push_back(8'($urandom_range(255, 0)));
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        int c;
        logic [7:0] ack;
        repeat (3) @(negedge clk_sys);
        check("rst_sck", SPI_SCK, 0);
        check("rst_ss2", SPI_SS2, 1);
        check("rst_di", SPI_DI, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_src_ready", src_ready, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // ACK pass with a start attempt while busy
        src_buf = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_download(8'h03, 8'h4B, 1'b1);
        finish_download("ack_pass", 8'h4B);

        // ACK fail: nothing beyond the ACK transaction
        src_buf = '{8'h55, 8'h66};
        start_download(8'h07, 8'h00, 1'b1);
        finish_download("ack_fail", 8'h00);

        // Odd length gets a pad byte
        src_buf = '{8'hAA, 8'hBB, 8'hCC};
        start_download(8'h10, 8'h4B, 1'b0);
        finish_download("odd_len", 8'h4B);

        // Source stall before byte 2
        fill_random(5);
        stall_at  = 2;
        stall_len = 100;
        start_download(8'h42, 8'h4B, 1'b0);
        c = 0;
        while (rdy_cnt < 2 && c < 5000) begin
            @(negedge clk_sys);
            c++;
        end
        check("stall_reach", 32'(rdy_cnt >= 2), 1);
        repeat (80) @(negedge clk_sys);
        check("stall_sck_low", SPI_SCK, 0);
        check("stall_ss2_low", SPI_SS2, 0);
        check("stall_busy", busy, 1);
        check("stall_rdy_hold", rdy_cnt, 2);
        finish_download("stall", 8'h4B);
        stall_at = -1;

        // Zero length
        src_buf.delete();
        start_download(8'h99, 8'h4B, 1'b0);
        finish_download("zero_len", 8'h4B);

        // Asynchronous reset in the middle of the pump transaction
        fill_random(6);
        start_download(8'h21, 8'h4B, 1'b0);
        c = 0;
        while (rdy_cnt < 1 && c < 5000) begin
            @(negedge clk_sys);
            c++;
        end
        check("rst_mid_reach", 32'(rdy_cnt >= 1), 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_ss2", SPI_SS2, 1);
        check("rst_mid_sck", SPI_SCK, 0);
        check("rst_mid_busy", busy, 0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        fill_random(4);
        start_download(8'h5A, 8'h4B, 1'b0);
        finish_download("after_rst", 8'h4B);

        // Randomized downloads with random source stalls
        stall_pct = 30;
        stall_max = 60;
        for (int r = 0; r < 6; r++) begin
            fill_random($urandom_range(9, 0));
            ack = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 0)) : 8'h4B;
            start_download(8'($urandom_range(255, 0)), ack, 1'b0);
            finish_download("rand", ack);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
